// File: rtl/sync_deglitch_multi.sv
// sync_deglitch_multi
//   Multi-channel input conditioner for asynchronous chip-boundary signals.
//   Each channel goes through an N-flop synchronizer, a debounce filter that
//   only accepts a new level after it has been seen for DEB_CYCLES consecutive
//   clocks, and a registered rise/fall pulse generator. Channels are fully
//   independent but share clk and n_rst.
//
// Parameters
//   WIDTH       number of channels (>=1)
//   STAGES      synchronizer depth (>=2)
//   DEB_CYCLES  consecutive differing cycles needed before filt_out follows (>=1)
//   RST_VAL     reset value of the sync chain and filt_out
//
// Ports
//   clk          in   system clock, rising edge
//   n_rst        in   synchronous active-low reset
//   async_in     in   [WIDTH] raw asynchronous inputs
//   sync_out     out  [WIDTH] synchronized, unfiltered level (last sync stage)
//   filt_out     out  [WIDTH] debounced level
//   rise_pulse   out  [WIDTH] one-cycle pulse when filt_out goes 0->1
//   fall_pulse   out  [WIDTH] one-cycle pulse when filt_out goes 1->0
//   evt          out  OR of all rise/fall pulses (combinational)
//   dbg_pending  out  [WIDTH] debounce FSM state per channel (1 = PENDING)

module sync_deglitch_multi #(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = 2,
  parameter int               DEB_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             evt,
  output logic [WIDTH-1:0] dbg_pending
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer chain: stage 0 captures the raw input, last stage is sync_out.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_sync[s] <= RST_VAL;
      end
    end else begin
      r_sync[0] <= async_in;
      for (int s = 1; s < STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign sync_out = r_sync[STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM + edge pulses, one instance of state per channel.
  // ---------------------------------------------------------------------------
  state_t           r_state     [WIDTH];
  state_t           w_state_nxt [WIDTH];
  logic [CW-1:0]    r_cnt       [WIDTH];
  logic [CW-1:0]    w_cnt_nxt   [WIDTH];
  logic [WIDTH-1:0] r_filt;
  logic [WIDTH-1:0] w_filt_nxt;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] w_fall_nxt;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_STABLE;
        r_cnt[i]   <= '0;
      end
      r_filt <= RST_VAL;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_filt <= w_filt_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  always_comb begin
    w_filt_nxt = r_filt;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];

      case (r_state[i])
        ST_STABLE: begin
          w_cnt_nxt[i] = '0;
          if (sync_out[i] != r_filt[i]) begin
            if (DEB_CYCLES == 1) begin
              // A single differing cycle is enough: accept it right away.
              w_filt_nxt[i] = sync_out[i];
              w_rise_nxt[i] = sync_out[i];
              w_fall_nxt[i] = ~sync_out[i];
            end else begin
              w_state_nxt[i] = ST_PENDING;
              w_cnt_nxt[i]   = CNT_ONE;
            end
          end
        end

        ST_PENDING: begin
          if (sync_out[i] == r_filt[i]) begin
            // Input went back before the window filled: treat as a glitch.
            w_state_nxt[i] = ST_STABLE;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_LAST) begin
            // This edge is the DEB_CYCLES-th consecutive differing one.
            w_filt_nxt[i]  = sync_out[i];
            w_rise_nxt[i]  = sync_out[i];
            w_fall_nxt[i]  = ~sync_out[i];
            w_state_nxt[i] = ST_STABLE;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end

        default: begin
          w_state_nxt[i] = ST_STABLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    dbg_pending = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dbg_pending[i] = (r_state[i] == ST_PENDING);
    end
  end

  assign filt_out   = r_filt;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign evt        = |(r_rise | r_fall);

endmodule

// File: tb/tb_sync_deglitch_multi.sv
module tb_sync_deglitch_multi;

  localparam int W   = 4;
  localparam int ST  = 2;
  localparam int DEB = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         n_rst;
  logic [W-1:0] async_in;
  logic [W-1:0] async_a;

  // Main instance, RST_VAL = 0
  logic [W-1:0] sync_out, filt_out, rise_pulse, fall_pulse, dbg_pending;
  logic         evt;

  // Second instance, RST_VAL = 4'hA
  logic [W-1:0] a_sync, a_filt, a_rise, a_fall, a_dbg;
  logic         a_evt;

  sync_deglitch_multi #(
    .WIDTH(W), .STAGES(ST), .DEB_CYCLES(DEB), .RST_VAL(4'h0)
  ) u_dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .async_in    (async_in),
    .sync_out    (sync_out),
    .filt_out    (filt_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .evt         (evt),
    .dbg_pending (dbg_pending)
  );

  sync_deglitch_multi #(
    .WIDTH(W), .STAGES(ST), .DEB_CYCLES(DEB), .RST_VAL(4'hA)
  ) u_dut_a (
    .clk         (clk),
    .n_rst       (n_rst),
    .async_in    (async_a),
    .sync_out    (a_sync),
    .filt_out    (a_filt),
    .rise_pulse  (a_rise),
    .fall_pulse  (a_fall),
    .evt         (a_evt),
    .dbg_pending (a_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the main instance.
  // The sync path is a pure delay line of STAGES samples; the filter counts how
  // many consecutive edges the synced level disagreed with the filtered level
  // and flips once that run reaches DEB.
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_filt, m_rise, m_fall, m_old;
  int           m_run [W];
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    if (n_rst === 1'b0) begin
      exp_q.delete();
      for (int s = 0; s < ST; s++) exp_q.push_back(4'h0);
      m_filt = 4'h0;
      m_rise = 4'h0;
      m_fall = 4'h0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_old  = exp_q[ST-1];
      m_rise = 4'h0;
      m_fall = 4'h0;
      for (int i = 0; i < W; i++) begin
        if (m_old[i] != m_filt[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_filt[i] = m_old[i];
            if (m_old[i]) m_rise[i] = 1'b1;
            else          m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      exp_q.push_front(async_in);
      void'(exp_q.pop_back());
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [W-1:0] exp_dbg;
      exp_dbg = '0;
      for (int i = 0; i < W; i++) exp_dbg[i] = (m_run[i] != 0);
      check("sync_out",    sync_out,    exp_q[ST-1]);
      check("filt_out",    filt_out,    m_filt);
      check("rise_pulse",  rise_pulse,  m_rise);
      check("fall_pulse",  fall_pulse,  m_fall);
      check("evt",         evt,         |(m_rise | m_fall));
      check("dbg_pending", dbg_pending, exp_dbg);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: apply inputs, let one rising edge happen, return at the falling edge
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic [W-1:0] a, input logic r);
    async_in = a;
    n_rst    = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  int k_hit;
  int cnt_a;
  int cnt_b;
  logic [W-1:0] acc;
  logic [W-1:0] rv;

  initial begin
    async_in = 4'h0;
    async_a  = 4'hA;
    n_rst    = 1'b0;

    // 1: reset with all inputs high, then release
    cyc(4'hF, 1'b0);
    cyc(4'hF, 1'b0);
    check("t1_rst_sync", sync_out, 4'h0);
    check("t1_rst_filt", filt_out, 4'h0);
    check("t1_rst_rise", rise_pulse, 4'h0);
    check("t1_rst_evt",  evt, 1'b0);
    cyc(4'hF, 1'b1);
    check("t1_sync_e1", sync_out, 4'h0);
    cyc(4'hF, 1'b1);
    check("t1_sync_e2", sync_out, 4'hF);
    cyc(4'hF, 1'b1);
    cyc(4'hF, 1'b1);
    cyc(4'hF, 1'b1);
    check("t1_filt_e5", filt_out, 4'h0);
    cyc(4'hF, 1'b1);
    check("t1_filt_e6", filt_out, 4'hF);
    check("t1_rise_e6", rise_pulse, 4'hF);
    check("t1_evt_e6",  evt, 1'b1);
    cyc(4'hF, 1'b1);
    check("t1_rise_e7", rise_pulse, 4'h0);
    check("t1_evt_e7",  evt, 1'b0);

    // 2: 3-cycle glitch on channel 0 never reaches filt_out
    cyc(4'h0, 1'b0);
    cyc(4'h0, 1'b0);
    cnt_a = 0;
    cnt_b = 0;
    acc   = 4'h0;
    for (int k = 0; k < 12; k++) begin
      cyc((k < 3) ? 4'h1 : 4'h0, 1'b1);
      cnt_a += int'(sync_out[0]);
      cnt_b += int'(|(rise_pulse | fall_pulse));
      acc   |= filt_out;
    end
    check("t2_sync_hi_cycles", cnt_a, 3);
    check("t2_pulses", cnt_b, 0);
    check("t2_filt", acc, 4'h0);

    // 3: channel 1 held high, then held low
    k_hit = 0;
    cnt_a = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(4'h2, 1'b1);
      if (rise_pulse[1]) begin
        cnt_a++;
        if (k_hit == 0) k_hit = k;
      end
    end
    check("t3_rise_latency", k_hit, 6);
    check("t3_rise_count", cnt_a, 1);
    check("t3_filt_hi", filt_out, 4'h2);
    k_hit = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(4'h0, 1'b1);
      if (fall_pulse[1] && k_hit == 0) k_hit = k;
    end
    check("t3_fall_latency", k_hit, 6);
    check("t3_filt_lo", filt_out, 4'h0);

    // 4: channel 2 rises while channel 3 falls on the same edge
    for (int k = 0; k < 8; k++) cyc(4'h8, 1'b1);
    check("t4_pre_filt", filt_out, 4'h8);
    k_hit = 0;
    cnt_a = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(4'h4, 1'b1);
      cnt_a += int'(evt);
      if (rise_pulse == 4'h4 && fall_pulse == 4'h8 && k_hit == 0) k_hit = k;
    end
    check("t4_both_edge", k_hit, 6);
    check("t4_evt_count", cnt_a, 1);
    check("t4_filt", filt_out, 4'h4);

    // 5: reset while channel 0 is mid-debounce
    cyc(4'h0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(4'h1, 1'b1);
    check("t5_pending", dbg_pending, 4'h1);
    check("t5_filt_pre", filt_out, 4'h0);
    cyc(4'h1, 1'b0);
    check("t5_rst_filt", filt_out, 4'h0);
    check("t5_rst_rise", rise_pulse, 4'h0);
    check("t5_rst_dbg",  dbg_pending, 4'h0);
    k_hit = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(4'h1, 1'b1);
      if (rise_pulse[0] && k_hit == 0) k_hit = k;
    end
    check("t5_restart_latency", k_hit, 6);

    // 6: second instance with RST_VAL = A
    async_a = 4'hA;
    cyc(4'h0, 1'b0);
    cyc(4'h0, 1'b0);
    check("t6_rst_filt", a_filt, 4'hA);
    check("t6_rst_sync", a_sync, 4'hA);
    cnt_a = 0;
    acc   = 4'h0;
    for (int k = 0; k < 8; k++) begin
      cyc(4'h0, 1'b1);
      cnt_a += int'(a_evt);
      acc   |= a_filt ^ 4'hA;
    end
    check("t6_hold_pulses", cnt_a, 0);
    check("t6_hold_filt_diff", acc, 4'h0);
    async_a = 4'h5;
    k_hit = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(4'h0, 1'b1);
      if (a_rise == 4'h5 && a_fall == 4'hA && k_hit == 0) k_hit = k;
    end
    check("t6_swap_edge", k_hit, 6);
    check("t6_swap_filt", a_filt, 4'h5);

    // Random phase: toggles with varied run lengths plus occasional resets
    rv = 4'h0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 7) == 0) rv[i] = ~rv[i];
      end
      async_a = 4'($urandom_range(0, 15));
      cyc(rv, ($urandom_range(0, 299) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
